// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg: constants and helpers shared by the MAC operand fork and its benches.
//   MAC_DW        default operand width
//   CH_A..CH_D    channel indices, NUM_CH channel count
//   mac_word_t    packed operand word, A in the most significant field
//   fld_lsb()     bit offset of a channel's field inside the packed word
//   pack_word()   builds a packed word from four operands
// ---------------------------------------------------------------------------
package mac_pkg;

  localparam int MAC_DW = 8;
  localparam int NUM_CH = 4;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;
  localparam int CH_D = 3;

  typedef struct packed {
    logic [MAC_DW-1:0] a;
    logic [MAC_DW-1:0] b;
    logic [MAC_DW-1:0] c;
    logic [MAC_DW-1:0] d;
  } mac_word_t;

  // Channel 0 (A) sits in the top field, channel NUM_CH-1 (D) at bit 0.
  function automatic int fld_lsb(input int ch, input int dw);
    return (NUM_CH - 1 - ch) * dw;
  endfunction

  function automatic mac_word_t pack_word(input logic [MAC_DW-1:0] a,
                                          input logic [MAC_DW-1:0] b,
                                          input logic [MAC_DW-1:0] c,
                                          input logic [MAC_DW-1:0] d);
    mac_word_t w;
    w.a = a;
    w.b = b;
    w.c = c;
    w.d = d;
    return w;
  endfunction

endpackage

// File: rtl/mac_operand_fifo.sv
// ---------------------------------------------------------------------------
// mac_operand_fifo: DEPTH x W synchronous FIFO, async active-low reset.
//   clk_i, rst_ni     clock / async active-low reset
//   push_i, wdata_i   write strobe and data (ignored when full)
//   pop_i             retire head (ignored when empty)
//   rdata_o           head word, read straight from the storage flops
//   full_o, empty_o   status, from registered state only
//   level_o           stored word count
// Storage is not reset; the pointers and count define what is valid.
// ---------------------------------------------------------------------------
module mac_operand_fifo #(
  parameter  int W     = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mac_operand_fork.sv
// ---------------------------------------------------------------------------
// mac_operand_fork: buffers packed {A,B,C,D} operand words and forks the
// head word onto four independent valid/ready channels.
//   clk, reset                  clock / async active-low reset
//   s_data, s_valid, s_ready    packed word slave port
//   X_data, X_valid, X_ready    operand channel X in {A,B,C,D}
//   level                       words held, including a partially sent head
//   busy                        level != 0
// Each channel has a done flag; the head retires once every channel has
// either finished earlier or is handshaking now, so each operand goes out
// exactly once even under independent stalls.
// ---------------------------------------------------------------------------
module mac_operand_fork
  import mac_pkg::*;
#(
  parameter  int DW    = MAC_DW,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH*DW-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [DW-1:0]        A_data,
  output logic                 A_valid,
  input  logic                 A_ready,
  output logic [DW-1:0]        B_data,
  output logic                 B_valid,
  input  logic                 B_ready,
  output logic [DW-1:0]        C_data,
  output logic                 C_valid,
  input  logic                 C_ready,
  output logic [DW-1:0]        D_data,
  output logic                 D_valid,
  input  logic                 D_ready,
  output logic [LW-1:0]        level,
  output logic                 busy
);

  logic [NUM_CH*DW-1:0]        head;
  logic [NUM_CH-1:0][DW-1:0]   ch_data;
  logic [NUM_CH-1:0]           ch_vld, ch_rdy, hs;
  logic [NUM_CH-1:0]           done_q, done_d;
  logic                        full, empty, push, pop;
  logic                        live_q;

  // live_q keeps s_ready low while in reset and up to the first edge after.
  assign s_ready = live_q && !full;
  assign push    = s_valid && s_ready;
  assign busy    = (level != '0);

  mac_operand_fifo #(
    .W     (NUM_CH*DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .wdata_i (s_data),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    localparam int LSB = fld_lsb(ch, DW);
    assign ch_data[ch] = head[LSB +: DW];
    assign ch_vld[ch]  = !empty && !done_q[ch];
  end

  assign hs  = ch_vld & ch_rdy;
  assign pop = !empty && (&(done_q | hs));

  always_comb begin
    done_d = done_q | hs;
    if (pop) done_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= '0;
      live_q <= 1'b0;
    end else begin
      done_q <= done_d;
      live_q <= 1'b1;
    end
  end

  assign ch_rdy[CH_A] = A_ready;
  assign ch_rdy[CH_B] = B_ready;
  assign ch_rdy[CH_C] = C_ready;
  assign ch_rdy[CH_D] = D_ready;

  assign A_data  = ch_data[CH_A];
  assign B_data  = ch_data[CH_B];
  assign C_data  = ch_data[CH_C];
  assign D_data  = ch_data[CH_D];
  assign A_valid = ch_vld[CH_A];
  assign B_valid = ch_vld[CH_B];
  assign C_valid = ch_vld[CH_C];
  assign D_valid = ch_vld[CH_D];

endmodule

// File: tb/tb_mac_operand_fork.sv
// ---------------------------------------------------------------------------
// tb_mac_operand_fork: table-driven and hand-written sequences for the
// directed cases, then random traffic checked against a per-channel
// delivery-count model of the operand stream.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_mac_operand_fork;
  import mac_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [4*DW-1:0] s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [DW-1:0]   A_data, B_data, C_data, D_data;
  logic            A_valid, B_valid, C_valid, D_valid;
  logic            A_ready = 1'b0, B_ready = 1'b0, C_ready = 1'b0, D_ready = 1'b0;
  logic [LW-1:0]   level;
  logic            busy;

  always #5 clk = ~clk;

  mac_operand_fork #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .A_data(A_data), .A_valid(A_valid), .A_ready(A_ready),
    .B_data(B_data), .B_valid(B_valid), .B_ready(B_ready),
    .C_data(C_data), .C_valid(C_valid), .C_ready(C_ready),
    .D_data(D_data), .D_valid(D_valid), .D_ready(D_ready),
    .level(level), .busy(busy)
  );

  // Bit 3 = A ... bit 0 = D, matching the packed field order.
  logic [3:0]  vld;
  logic [31:0] out_word;
  assign vld      = {A_valid, B_valid, C_valid, D_valid};
  assign out_word = {A_data, B_data, C_data, D_data};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ev, input logic [31:0] ew,
                         input int el, input logic es);
    logic [31:0] m;
    m = {{8{ev[3]}}, {8{ev[2]}}, {8{ev[1]}}, {8{ev[0]}}};
    chk({tag, " valid"},   32'(vld),      32'(ev));
    chk({tag, " data"},    out_word & m,  ew & m);
    chk({tag, " level"},   32'(level),    32'(el));
    chk({tag, " s_ready"}, 32'(s_ready),  32'(es));
    chk({tag, " busy"},    32'(busy),     32'(el != 0));
  endtask

  task automatic set_rdy(input logic [3:0] r);
    {A_ready, B_ready, C_ready, D_ready} = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic [3:0]  rdy;
    logic [3:0]  ev;
    logic [31:0] ew;
    int          el;
    logic        es;
  } vec_t;

  function automatic vec_t mk(input logic sv, input logic [31:0] sd, input logic [3:0] rdy,
                              input logic [3:0] ev, input logic [31:0] ew, input int el,
                              input logic es);
    vec_t v;
    v.sv = sv; v.sd = sd; v.rdy = rdy; v.ev = ev; v.ew = ew; v.el = el; v.es = es;
    return v;
  endfunction

  initial begin
    vec_t        tv[$];
    logic [31:0] w1, w2, w3, w11;
    logic [31:0] wf[5];
    logic [31:0] mq[$];
    int          del[4];

    w1  = pack_word(8'd3, 8'd2, 8'd1, 8'd2);
    w2  = pack_word(8'd6, 8'd4, 8'd2, 8'd4);
    w3  = pack_word(8'd9, 8'd6, 8'd3, 8'd6);
    w11 = pack_word(8'd1, 8'd1, 8'd1, 8'd1);
    for (int k = 0; k < 5; k++)
      wf[k] = pack_word(8'(8'h10 + k), 8'(8'h20 + k), 8'(8'h30 + k), 8'(8'h40 + k));

    // Back-to-back stream with all readies high: one word per cycle.
    tv.push_back(mk(1, w1, 4'hF, 4'h0, 0,  0, 1));
    tv.push_back(mk(1, w2, 4'hF, 4'hF, w1, 1, 1));
    tv.push_back(mk(1, w3, 4'hF, 4'hF, w2, 1, 1));
    tv.push_back(mk(0, 0,  4'hF, 4'hF, w3, 1, 1));
    tv.push_back(mk(0, 0,  4'hF, 4'h0, 0,  0, 1));
    // B stalled for three cycles; A, C, D go out once and drop.
    tv.push_back(mk(1, w1, 4'hF, 4'h0, 0,  0, 1));
    tv.push_back(mk(0, 0,  4'hB, 4'hF, w1, 1, 1));
    tv.push_back(mk(0, 0,  4'hB, 4'h4, w1, 1, 1));
    tv.push_back(mk(0, 0,  4'hB, 4'h4, w1, 1, 1));
    tv.push_back(mk(0, 0,  4'hF, 4'h4, w1, 1, 1));
    tv.push_back(mk(0, 0,  4'hF, 4'h0, 0,  0, 1));

    // Reset state, then release between edges.
    #2;
    chk_out("reset", 4'h0, 0, 0, 0);
    #10;
    reset = 1'b1;
    #1;
    chk("s_ready before first edge", 32'(s_ready), 32'd0);
    tick();

    // Idle after reset.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_out("idle", 4'h0, 0, 0, 1);
      tick();
    end

    for (int i = 0; i < tv.size(); i++) begin
      s_valid = tv[i].sv;
      s_data  = tv[i].sd;
      set_rdy(tv[i].rdy);
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), tv[i].ev, tv[i].ew, tv[i].el, tv[i].es);
      tick();
    end

    // Fill to full with all readies low; fifth word is held off.
    set_rdy(4'h0);
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1;
      s_data  = wf[k];
      @(negedge clk);
      chk($sformatf("fill%0d s_ready", k), 32'(s_ready), 32'd1);
      tick();
    end
    s_data = wf[4];
    @(negedge clk); chk_out("full", 4'hF, wf[0], 4, 0); tick();
    @(negedge clk); chk_out("full hold", 4'hF, wf[0], 4, 0);
    tick();

    // Raise all readies while full: pop now, s_ready the cycle after.
    set_rdy(4'hF);
    @(negedge clk); chk_out("full pop", 4'hF, wf[0], 4, 0); tick();
    @(negedge clk); chk_out("after pop", 4'hF, wf[1], 3, 1); tick();
    s_valid = 1'b0;
    @(negedge clk); chk_out("drain2", 4'hF, wf[2], 3, 1); tick();
    @(negedge clk); chk_out("drain3", 4'hF, wf[3], 2, 1); tick();
    @(negedge clk); chk_out("drain4", 4'hF, wf[4], 1, 1); tick();
    @(negedge clk); chk_out("drained", 4'h0, 0, 0, 1); tick();

    // Reset with two words queued and A already delivered.
    set_rdy(4'h0);
    s_valid = 1'b1; s_data = wf[0]; tick();
    s_data  = wf[1]; tick();
    s_valid = 1'b0;
    set_rdy(4'h8);
    @(negedge clk); chk_out("pre A", 4'hF, wf[0], 2, 1); tick();
    set_rdy(4'h0);
    @(negedge clk); chk_out("A done", 4'h7, wf[0], 2, 1);
    reset = 1'b0;
    #1;
    chk_out("async reset", 4'h0, 0, 0, 0);
    #1;
    reset = 1'b1;
    tick();
    s_valid = 1'b1; s_data = w11;
    @(negedge clk); chk_out("post reset", 4'h0, 0, 0, 1); tick();
    s_valid = 1'b0;
    @(negedge clk); chk_out("new word", 4'hF, w11, 1, 1); tick();
    set_rdy(4'hF);
    @(negedge clk); chk_out("new word2", 4'hF, w11, 1, 1); tick();
    @(negedge clk); chk_out("empty again", 4'h0, 0, 0, 1); tick();

    // Random traffic. Model: list of accepted words plus, per channel, how
    // many operands that channel has delivered. The head is the word the
    // slowest channel is on; a channel is valid when it is not ahead of it.
    for (int i = 0; i < 4; i++) del[i] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int          mn, el;
      logic [3:0]  ev, r;
      logic [31:0] ew, hw;
      logic        es;
      int          rp;
      rp = (cyc / 250) % 3;  // vary back-pressure intensity by phase
      if (cyc >= 1480) begin
        s_valid = 1'b0;
        r = 4'hF;
      end else begin
        s_valid = ($urandom_range(0, 9) < 6);
        s_data  = $urandom;
        for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 3) >= rp);
      end
      set_rdy(r);
      @(negedge clk);
      mn = del[0];
      for (int i = 1; i < 4; i++) if (del[i] < mn) mn = del[i];
      el = mq.size() - mn;
      es = (el < DEPTH);
      ew = '0;
      for (int i = 0; i < 4; i++) begin
        ev[3-i] = (mq.size() > mn) && (del[i] == mn);
        if (ev[3-i]) begin
          hw = mq[del[i]];
          ew[(3-i)*8 +: 8] = hw[(3-i)*8 +: 8];
        end
      end
      chk_out("rnd", ev, ew, el, es);
      for (int i = 0; i < 4; i++) if (ev[3-i] && r[3-i]) del[i]++;
      if (s_valid && es) mq.push_back(s_data);
      tick();
    end
    @(negedge clk);
    chk("rnd final level", 32'(level), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mac_operand_fork.md
Name: mac_operand_fork

Overview:
Transmit-side companion to the MAC pipeline. Takes one packed operand word {A,B,C,D} over a single valid/ready slave port and buffers it in a small FIFO. Forks each word onto the four independent operand channels that the MAC consumes.
Guarantees every operand of a word is delivered exactly once and in order, even when the four channel readies stall independently.

Parameters:
DW, 8, width of each operand channel
DEPTH, 4, FIFO depth in operand words; power of two, at least 2
LW, $clog2(DEPTH)+1, width of the fill-level output (derived, not overridden)

Ports:
clk  input  1  single clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
s_data  input  4*DW  packed word: A=[4DW-1:3DW], B=[3DW-1:2DW], C=[2DW-1:DW], D=[DW-1:0]
s_valid  input  1  s_data valid
s_ready  output  1  FIFO can accept a word
A_data  output  DW  operand A of head word
A_valid  output  1  A channel valid
A_ready  input  1  A channel accepted
B_data/B_valid/B_ready  same as A, for operand B
C_data/C_valid/C_ready  same as A, for operand C
D_data/D_valid/D_ready  same as A, for operand D
level  output  LW  number of words in FIFO, including a partially delivered head
busy  output  1  level != 0

Behaviour:
- Reset (reset=0, takes effect asynchronously):
  - s_ready=0, all X_valid=0, level=0, busy=0.
  - FIFO pointers and the four done flags are cleared; FIFO contents are discarded.
  - s_ready=1 from the first clock edge after reset is released.
- Push:
  - s_ready = !full, derived from registered state only; no combinational path from any X_ready.
  - Word is written when s_valid && s_ready at a clock edge.
  - When full, s_ready stays 0 in a cycle where a pop occurs. It rises the cycle after the pop.
- Latency: a word pushed at edge N drives X_data/X_valid in the cycle after edge N. There is no write-to-read bypass.
- Fork:
  - X_data = the corresponding field of the head word.
  - X_valid = !empty && !done_X.
  - done_X is set at an edge where X_valid && X_ready.
- Pop:
  - The head retires at the edge where every channel is either already done or handshaking in that cycle.
  - At that edge all done flags are cleared and the read pointer advances.
  - If the FIFO is not empty afterwards, the next head is valid on all four channels in the next cycle. With all readies high, throughput is 1 word per cycle.
- Stability: while X_valid=1, X_data and X_valid hold until that channel handshakes. X_valid never drops before its handshake.
- Simultaneous push and pop when not full: both occur and level is unchanged.
- level counts up on push only, down on pop only, and is unchanged on both. It saturates at neither end; overflow and underflow are impossible by construction.
- Empty: all X_valid=0, and X_data holds its last value (don't-care).
- Reset mid-word: partially delivered operands are lost and are not re-sent after reset.

Decomposition:
- Shared package mac_pkg:
  - DW default
  - channel index constants CH_A=0..CH_D=3 and NUM_CH=4
  - field slice offsets for the packed word
  - a packing function used by both the fork and the benches
- One sub-module: mac_operand_fifo. It is a synchronous DEPTH x 4*DW FIFO with push/pop/full/empty/level, async active-low reset, and registered read data.
- The done flags and the fork/pop logic live in mac_operand_fork.

Test Plan:
1. All readies high; push {3,2,1,2},{6,4,2,4},{9,6,3,6} back-to-back.
   -> First valids appear one cycle after the first push with A=3,B=2,C=1,D=2. One word per cycle follows, in order, and level returns to 0.
2. B_ready low for 3 cycles, others high, word {3,2,1,2}.
   -> A, C and D each handshake once and their valids drop. B_valid stays high with B_data=2. The pop happens on the cycle B_ready rises, and nothing is duplicated.
3. All readies low; push 5 words.
   -> s_ready=0 after the 4th push and level=4. The 5th word is held by the source, and no X_valid data changes.
4. FIFO full, s_valid held high, all readies raised.
   -> Pop occurs that cycle, s_ready=1 the next cycle, and the 5th word is delivered after the 4th, in order.
5. Reset pulled low with 2 words queued and A already done.
   -> All valids=0, s_ready=0 and level=0 immediately, without waiting for a clock edge. After release, a new word {1,1,1,1} is presented on all four channels, including A.
6. s_valid=0 throughout after reset.
   -> All X_valid=0, level=0, busy=0, and s_ready=1.
